// File: rtl/ntm_scalar_adder.sv
// Registered unsigned scalar adder producing a full-precision (carry-inclusive) sum.
// Define NTM_SCALAR_ADDER_INREG_EN to add an operand register stage (latency 2 instead of 1).
module ntm_scalar_adder #(
   parameter int DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] in1,
   input  logic [DATA_SIZE-1:0] in2,
   output logic [DATA_SIZE:0]   out
);

   logic [DATA_SIZE-1:0] op1;
   logic [DATA_SIZE-1:0] op2;
   logic [DATA_SIZE:0]   sum;

`ifdef NTM_SCALAR_ADDER_INREG_EN
   logic [DATA_SIZE-1:0] in1_reg;
   logic [DATA_SIZE-1:0] in2_reg;

   // Operand capture stage ahead of the adder, for timing closure in wide trainers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in1_reg <= '0;
         in2_reg <= '0;
      end else begin
         in1_reg <= in1;
         in2_reg <= in2;
      end
   end

   assign op1 = in1_reg;
   assign op2 = in2_reg;
`else
   assign op1 = in1;
   assign op2 = in2;
`endif

   // Zero-extend both operands so the carry lands in the extra MSB and nothing overflows.
   assign sum = {1'b0, op1} + {1'b0, op2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= '0;
      end else begin
         out <= sum;
      end
   end

endmodule

// File: tb/tb_ntm_scalar_adder.sv
// Randomised self-checking bench for ntm_scalar_adder; the reference model is a queue of
// pending sums whose depth follows the build's latency.
module tb_ntm_scalar_adder;

   localparam int DATA_SIZE = 8;
`ifdef NTM_SCALAR_ADDER_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic                 clk;
   logic                 rst;
   logic [DATA_SIZE-1:0] in1;
   logic [DATA_SIZE-1:0] in2;
   logic [DATA_SIZE:0]   out;

   int checks;
   int failures;
   int pipe[$];
   int exp_val;

   ntm_scalar_adder #(.DATA_SIZE(DATA_SIZE)) dut (
      .clk(clk),
      .rst(rst),
      .in1(in1),
      .in2(in2),
      .out(out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // After reset the pipeline holds LAT-1 zero results still to emerge.
   task automatic reset_model();
      pipe.delete();
      for (int i = 0; i < LAT - 1; i++) pipe.push_back(0);
   endtask

   // Drive operands mid-cycle, take one rising edge, and advance the model to match.
   task automatic applyStimulus(input int a, input int b);
      @(negedge clk);
      in1 = a[DATA_SIZE-1:0];
      in2 = b[DATA_SIZE-1:0];
      @(posedge clk);
      #1;
      pipe.push_back(a + b);
      exp_val = pipe.pop_front();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out !== 9'd0) begin
         failures++;
         $display("[TB] FAIL reset_initial got=%0d exp=0", out);
      end
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      applyStimulus(7, 9);
      applyStimulus(0, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out !== 9'd0) begin
         failures++;
         $display("[TB] FAIL reset_pulse got=%0d exp=0", out);
      end
      #1;
      rst = 1'b0;
      reset_model();
      applyStimulus(0, 0);
      checks++;
      if (out !== exp_val[DATA_SIZE:0]) begin
         failures++;
         $display("[TB] FAIL reset_hold got=%0d exp=%0d", out, exp_val);
      end
   endtask

   task automatic test_basic_add();
      applyStimulus(5, 2);
      checks++;
      if (out !== exp_val[DATA_SIZE:0]) begin
         failures++;
         $display("[TB] FAIL basic_add_edge1 got=%0d exp=%0d", out, exp_val);
      end
      for (int i = 1; i < LAT; i++) begin
         applyStimulus(5, 2);
         checks++;
         if (out !== 9'd7) begin
            failures++;
            $display("[TB] FAIL basic_add_final got=%0d exp=7", out);
         end
      end
      if (LAT == 1) begin
         checks++;
         if (out !== 9'd7) begin
            failures++;
            $display("[TB] FAIL basic_add_value got=%0d exp=7", out);
         end
      end
   endtask

   task automatic test_carry();
      int pairs[4][2] = '{'{255, 255}, '{128, 128}, '{0, 0}, '{0, 0}};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(pairs[i][0], pairs[i][1]);
         checks++;
         if (out !== exp_val[DATA_SIZE:0]) begin
            failures++;
            $display("[TB] FAIL carry_%0d got=%0d exp=%0d", i, out, exp_val);
         end
      end
   endtask

   task automatic test_back_to_back();
      int pairs[3][2] = '{'{1, 1}, '{10, 20}, '{200, 100}};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(pairs[i][0], pairs[i][1]);
         checks++;
         if (out !== exp_val[DATA_SIZE:0]) begin
            failures++;
            $display("[TB] FAIL stream_%0d got=%0d exp=%0d", i, out, exp_val);
         end
      end
      for (int i = 1; i < LAT; i++) applyStimulus(200, 100);
      checks++;
      if (out !== 9'd300) begin
         failures++;
         $display("[TB] FAIL stream_last got=%0d exp=300", out);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out !== 9'd0) begin
         failures++;
         $display("[TB] FAIL async_reset_immediate got=%0d exp=0", out);
      end
      in1 = 8'($urandom_range(255));
      in2 = 8'($urandom_range(255));
      @(posedge clk);
      #1;
      checks++;
      if (out !== 9'd0) begin
         failures++;
         $display("[TB] FAIL async_reset_held got=%0d exp=0", out);
      end
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      for (int i = 0; i < LAT; i++) applyStimulus(3, 4);
      checks++;
      if (out !== 9'd7) begin
         failures++;
         $display("[TB] FAIL async_reset_release got=%0d exp=7", out);
      end
   endtask

   task automatic test_random();
      int a;
      int b;
      for (int i = 0; i < 60; i++) begin
         a = int'($urandom_range(255));
         b = int'($urandom_range(255));
         if (i % 10 == 0) a = 255;
         applyStimulus(a, b);
         checks++;
         if (out !== exp_val[DATA_SIZE:0]) begin
            failures++;
            $display("[TB] FAIL random_%0d got=%0d exp=%0d", i, out, exp_val);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      in1      = '0;
      in2      = '0;
      reset_model();
      test_reset();
      test_basic_add();
      test_carry();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
